bank_cmd_scheduler: RTL and testbench

BANK_CMD_SCHEDULER -- requirements
Module: bank_cmd_scheduler

---
 rtl/bank_cmd_scheduler.sv | 227 ++++++++++++++++++++++
 tb/tb_bank_cmd_scheduler.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bank_cmd_scheduler.sv
// In-order DRAM bank command scheduler: turns one request at a time into
// PRECHARGE/ACTIVATE/READ/WRITE commands using an open-row table and latency counters.
module bank_cmd_scheduler #(
    parameter int unsigned ACTIVATION_LATENCY = 8,
    parameter int unsigned PRECHARGE_LATENCY  = 5,
    parameter int unsigned BURST_GAP          = 8,
    parameter int unsigned BANK_GROUPS        = 2,
    parameter int unsigned BANKS_PER_GROUP    = 4,
    parameter int unsigned ROW_BITS           = 8,
    parameter int unsigned COL_BITS           = 4,
    localparam int unsigned BG_W = (BANK_GROUPS > 1) ? $clog2(BANK_GROUPS) : 1,
    localparam int unsigned BA_W = (BANKS_PER_GROUP > 1) ? $clog2(BANKS_PER_GROUP) : 1
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 req_valid_in,
    output logic                 req_ready_out,
    input  logic                 req_write_in,
    input  logic [BG_W-1:0]      req_bg_in,
    input  logic [BA_W-1:0]      req_ba_in,
    input  logic [ROW_BITS-1:0]  req_row_in,
    input  logic [COL_BITS-1:0]  req_col_in,
    input  logic [7:0][63:0]     req_data_in,
    output logic                 cmd_valid_out,
    output logic [2:0]           cmd_out,
    output logic [BG_W-1:0]      bg_out,
    output logic [BA_W-1:0]      ba_out,
    output logic [ROW_BITS-1:0]  row_out,
    output logic [COL_BITS-1:0]  col_out,
    output logic [7:0][63:0]     val_out
);

    localparam int unsigned NUM_BANKS = BANK_GROUPS * BANKS_PER_GROUP;
    localparam int unsigned IDX_W     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int unsigned MAX_LAT_A = (ACTIVATION_LATENCY > PRECHARGE_LATENCY) ?
                                        ACTIVATION_LATENCY : PRECHARGE_LATENCY;
    localparam int unsigned MAX_LAT   = (MAX_LAT_A > BURST_GAP) ? MAX_LAT_A : BURST_GAP;
    localparam int unsigned CNT_W     = (MAX_LAT > 0) ? $clog2(MAX_LAT + 1) : 1;
    // Wait states cover latency-1 cycles after the issue cycle; latency <= 1 skips them.
    localparam int unsigned PRE_LD    = (PRECHARGE_LATENCY >= 2) ? PRECHARGE_LATENCY - 2 : 0;
    localparam int unsigned ACT_LD    = (ACTIVATION_LATENCY >= 2) ? ACTIVATION_LATENCY - 2 : 0;
    localparam int unsigned GAP_LD    = (BURST_GAP >= 1) ? BURST_GAP - 1 : 0;
    localparam bit          PRE_SKIP  = (PRECHARGE_LATENCY <= 1);
    localparam bit          ACT_SKIP  = (ACTIVATION_LATENCY <= 1);

    localparam logic [2:0] CMD_READ  = 3'd0;
    localparam logic [2:0] CMD_WRITE = 3'd1;
    localparam logic [2:0] CMD_ACT   = 3'd2;
    localparam logic [2:0] CMD_PRE   = 3'd3;

    typedef enum logic [2:0] {
        S_IDLE, S_DECIDE, S_PRE, S_PRE_WAIT, S_ACT, S_ACT_WAIT, S_COL
    } state_t;

    state_t               state, state_nx;
    logic [CNT_W-1:0]     wait_cnt, wait_nx;
    logic [CNT_W-1:0]     gap_cnt, gap_nx;

    logic                 lat_write;
    logic [BG_W-1:0]      lat_bg;
    logic [BA_W-1:0]      lat_ba;
    logic [ROW_BITS-1:0]  lat_row;
    logic [COL_BITS-1:0]  lat_col;
    logic [7:0][63:0]     lat_data;

    logic [NUM_BANKS-1:0] open_q;
    logic [ROW_BITS-1:0]  row_q [NUM_BANKS];

    logic                 accept_c;
    logic [IDX_W-1:0]     idx_c;
    logic                 hit_c;

    logic                 cmd_valid_d;
    logic [2:0]           cmd_d;
    logic [BG_W-1:0]      bg_d;
    logic [BA_W-1:0]      ba_d;
    logic [ROW_BITS-1:0]  row_d;
    logic [COL_BITS-1:0]  col_d;
    logic [7:0][63:0]     val_d;
    logic                 ready_d;

    assign accept_c = req_valid_in && req_ready_out;
    assign idx_c    = IDX_W'(lat_bg) * IDX_W'(BANKS_PER_GROUP) + IDX_W'(lat_ba);
    assign hit_c    = open_q[idx_c] && (row_q[idx_c] == lat_row);

    // State and counter registers
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            gap_cnt  <= '0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_nx;
            gap_cnt  <= gap_nx;
        end
    end

    // Next state, wait counter and column gap counter
    always_comb begin
        state_nx = state;
        wait_nx  = wait_cnt;
        gap_nx   = (gap_cnt == '0) ? '0 : gap_cnt - CNT_W'(1);
        unique case (state)
            S_IDLE:     if (accept_c) state_nx = S_DECIDE;
            S_DECIDE: begin
                if (hit_c)              state_nx = S_COL;
                else if (open_q[idx_c]) state_nx = S_PRE;
                else                    state_nx = S_ACT;
            end
            S_PRE: begin
                if (PRE_SKIP) state_nx = S_ACT;
                else begin
                    state_nx = S_PRE_WAIT;
                    wait_nx  = CNT_W'(PRE_LD);
                end
            end
            S_PRE_WAIT: begin
                if (wait_cnt == '0) state_nx = S_ACT;
                else                wait_nx  = wait_cnt - CNT_W'(1);
            end
            S_ACT: begin
                if (ACT_SKIP) state_nx = S_COL;
                else begin
                    state_nx = S_ACT_WAIT;
                    wait_nx  = CNT_W'(ACT_LD);
                end
            end
            S_ACT_WAIT: begin
                if (wait_cnt == '0) state_nx = S_COL;
                else                wait_nx  = wait_cnt - CNT_W'(1);
            end
            S_COL: begin
                if (gap_cnt == '0) begin
                    state_nx = S_IDLE;
                    gap_nx   = CNT_W'(GAP_LD);
                end
            end
            default:    state_nx = S_IDLE;
        endcase
    end

    // Output decode one cycle ahead so the command lands in the cycle its state is entered
    always_comb begin
        cmd_valid_d = 1'b0;
        cmd_d       = CMD_READ;
        bg_d        = '0;
        ba_d        = '0;
        row_d       = '0;
        col_d       = '0;
        val_d       = '0;
        ready_d     = (state_nx == S_IDLE);
        unique case (state_nx)
            S_PRE: begin
                cmd_valid_d = 1'b1;
                cmd_d       = CMD_PRE;
            end
            S_ACT: begin
                cmd_valid_d = 1'b1;
                cmd_d       = CMD_ACT;
            end
            S_COL: begin
                if (gap_nx == '0) begin
                    cmd_valid_d = 1'b1;
                    cmd_d       = lat_write ? CMD_WRITE : CMD_READ;
                    col_d       = lat_col;
                    val_d       = lat_write ? lat_data : '0;
                end
            end
            default: ;
        endcase
        if (cmd_valid_d) begin
            bg_d  = lat_bg;
            ba_d  = lat_ba;
            row_d = lat_row;
        end
    end

    // Registered outputs
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cmd_valid_out <= 1'b0;
            cmd_out       <= '0;
            bg_out        <= '0;
            ba_out        <= '0;
            row_out       <= '0;
            col_out       <= '0;
            val_out       <= '0;
            req_ready_out <= 1'b0;
        end else begin
            cmd_valid_out <= cmd_valid_d;
            cmd_out       <= cmd_d;
            bg_out        <= bg_d;
            ba_out        <= ba_d;
            row_out       <= row_d;
            col_out       <= col_d;
            val_out       <= val_d;
            req_ready_out <= ready_d;
        end
    end

    // Open-row table
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            open_q <= '0;
            for (int i = 0; i < int'(NUM_BANKS); i++) row_q[i] <= '0;
        end else if (state == S_PRE) begin
            open_q[idx_c] <= 1'b0;
        end else if (state == S_ACT) begin
            open_q[idx_c] <= 1'b1;
            row_q[idx_c]  <= lat_row;
        end
    end

    // Request capture
    always_ff @(posedge clk_in) begin
        if (accept_c) begin
            lat_write <= req_write_in;
            lat_bg    <= req_bg_in;
            lat_ba    <= req_ba_in;
            lat_row   <= req_row_in;
            lat_col   <= req_col_in;
            lat_data  <= req_data_in;
        end
    end

endmodule

// File: tb/tb_bank_cmd_scheduler.sv
// Randomized scoreboard bench for bank_cmd_scheduler against a cycle-timed
// reference model of the open-row / latency / burst-gap rules.
module tb_bank_cmd_scheduler;

    localparam int AL = 8;
    localparam int PL = 5;
    localparam int BG = 8;

    logic             clk_in = 1'b0;
    logic             rst_in = 1'b1;
    logic             req_valid_in = 1'b0;
    logic             req_ready_out;
    logic             req_write_in = 1'b0;
    logic [0:0]       req_bg_in = '0;
    logic [1:0]       req_ba_in = '0;
    logic [7:0]       req_row_in = '0;
    logic [3:0]       req_col_in = '0;
    logic [7:0][63:0] req_data_in = '0;
    logic             cmd_valid_out;
    logic [2:0]       cmd_out;
    logic [0:0]       bg_out;
    logic [1:0]       ba_out;
    logic [7:0]       row_out;
    logic [3:0]       col_out;
    logic [7:0][63:0] val_out;

    bank_cmd_scheduler dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
        .req_write_in(req_write_in), .req_bg_in(req_bg_in), .req_ba_in(req_ba_in),
        .req_row_in(req_row_in), .req_col_in(req_col_in), .req_data_in(req_data_in),
        .cmd_valid_out(cmd_valid_out), .cmd_out(cmd_out), .bg_out(bg_out),
        .ba_out(ba_out), .row_out(row_out), .col_out(col_out), .val_out(val_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        longint           cyc;
        logic [2:0]       cmd;
        logic [0:0]       bg;
        logic [1:0]       ba;
        logic [7:0]       row;
        logic [3:0]       col;
        logic [7:0][63:0] data;
    } exp_t;

    exp_t   q[$];
    int     vectors = 0;
    int     miscompares = 0;
    longint cyc = 0;
    bit     armed = 0;
    bit     prev_rst = 0;

    bit         m_open [8];
    logic [7:0] m_row  [8];
    bit         inflight = 0;
    longint     col_cyc = 0;
    longint     last_col = -1000;
    bit         ready_exp = 0;
    int         acc_count = 0;

    always @(posedge clk_in) cyc++;

    function automatic void push_cmd(longint c, logic [2:0] k, logic [3:0] col, logic [7:0][63:0] d);
        exp_t e;
        e.cyc = c; e.cmd = k; e.bg = req_bg_in; e.ba = req_ba_in; e.row = req_row_in;
        e.col = col; e.data = d;
        q.push_back(e);
    endfunction

    // Reference model: expected ready and command schedule derived from the accept cycle
    always @(negedge clk_in) begin
        bit     rdy_nx;
        int     idx;
        longint t0, cc;
        rdy_nx = ready_exp;
        if (armed) begin
            vectors++;
            if (req_ready_out !== ready_exp) begin
                miscompares++;
                $display("FAIL ready cyc=%0d got=%b exp=%b", cyc, req_ready_out, ready_exp);
            end
        end
        if (rst_in) begin
            armed = 1;
            while (q.size() > 0 && q[$].cyc > cyc) void'(q.pop_back());
            for (int i = 0; i < 8; i++) m_open[i] = 0;
            inflight = 0;
            last_col = -1000;
            rdy_nx = 0;
        end else if (armed) begin
            if (req_valid_in && ready_exp) begin
                idx = int'(req_bg_in) * 4 + int'(req_ba_in);
                t0 = cyc + 2;
                if (m_open[idx] && m_row[idx] == req_row_in) begin
                    cc = t0;
                end else if (!m_open[idx]) begin
                    push_cmd(t0, 3'd2, 4'd0, '0);
                    cc = t0 + AL;
                end else begin
                    push_cmd(t0, 3'd3, 4'd0, '0);
                    push_cmd(t0 + PL, 3'd2, 4'd0, '0);
                    cc = t0 + PL + AL;
                end
                if (cc < last_col + BG) cc = last_col + BG;
                push_cmd(cc, req_write_in ? 3'd1 : 3'd0, req_col_in,
                         req_write_in ? req_data_in : '0);
                last_col = cc;
                col_cyc = cc;
                m_open[idx] = 1;
                m_row[idx] = req_row_in;
                inflight = 1;
                rdy_nx = 0;
                acc_count++;
            end else if (inflight && col_cyc == cyc) begin
                inflight = 0;
                rdy_nx = 1;
            end else begin
                rdy_nx = !inflight;
            end
        end
        ready_exp = rdy_nx;
    end

    // Monitor: pops the scoreboard whenever the DUT presents a command
    always @(negedge clk_in) begin
        exp_t e;
        if (prev_rst) begin
            vectors++;
            if (cmd_valid_out !== 1'b0 || cmd_out !== 3'd0 || bg_out !== '0 || ba_out !== '0 ||
                row_out !== '0 || col_out !== '0 || val_out !== '0) begin
                miscompares++;
                $display("FAIL reset_outputs cyc=%0d valid=%b cmd=%0d row=%0d col=%0d",
                         cyc, cmd_valid_out, cmd_out, row_out, col_out);
            end
        end
        prev_rst = rst_in;
        if (armed) begin
            if (cmd_valid_out === 1'b1) begin
                vectors++;
                if (q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_cmd cyc=%0d got cmd=%0d row=%0d", cyc, cmd_out, row_out);
                end else begin
                    e = q.pop_front();
                    if (e.cyc != cyc || e.cmd !== cmd_out || e.bg !== bg_out || e.ba !== ba_out ||
                        e.row !== row_out || e.col !== col_out || e.data !== val_out) begin
                        miscompares++;
                        $display("FAIL cmd got cyc=%0d cmd=%0d bg=%0d ba=%0d row=%0d col=%0d val0=%h exp cyc=%0d cmd=%0d bg=%0d ba=%0d row=%0d col=%0d val0=%h",
                                 cyc, cmd_out, bg_out, ba_out, row_out, col_out, val_out[0],
                                 e.cyc, e.cmd, e.bg, e.ba, e.row, e.col, e.data[0]);
                    end
                end
            end else if (q.size() > 0 && q[0].cyc <= cyc) begin
                vectors++;
                miscompares++;
                e = q.pop_front();
                $display("FAIL missing_cmd cyc=%0d got none exp cmd=%0d row=%0d", cyc, e.cmd, e.row);
            end
        end
    end

    task automatic send(bit w, logic [0:0] bgv, logic [1:0] bav, logic [7:0] r, logic [3:0] c,
                        bit hold);
        int start;
        bit got;
        start = acc_count;
        got = 0;
        req_write_in = w; req_bg_in = bgv; req_ba_in = bav; req_row_in = r; req_col_in = c;
        for (int i = 0; i < 8; i++) req_data_in[i] = {$urandom, $urandom};
        req_valid_in = 1'b1;
        for (int n = 0; n < 400 && !got; n++) begin
            @(posedge clk_in);
            if (acc_count != start) got = 1;
        end
        #1;
        if (!got) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout cyc=%0d got no accept exp accept", cyc);
        end
        if (!hold) begin
            req_valid_in = 1'b0;
            req_row_in = 8'($urandom);
            req_col_in = 4'($urandom);
            req_write_in = 1'($urandom);
        end
    endtask

    task automatic do_reset(int n);
        rst_in = 1'b1;
        req_valid_in = 1'b0;
        repeat (n) @(posedge clk_in);
        #1 rst_in = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    initial begin
        bit done;
        repeat (3) @(posedge clk_in);
        #1 rst_in = 1'b0;
        idle(6);
        // Directed: miss, gap-limited hit, conflict write, other bank then hit
        send(1'b0, 1'b0, 2'd0, 8'd5, 4'd3, 1'b1);
        send(1'b0, 1'b0, 2'd0, 8'd5, 4'd7, 1'b1);
        send(1'b1, 1'b0, 2'd0, 8'd9, 4'd1, 1'b0);
        idle(2);
        send(1'b1, 1'b1, 2'd3, 8'd2, 4'd4, 1'b1);
        send(1'b0, 1'b0, 2'd0, 8'd9, 4'd2, 1'b0);
        // Reset during precharge wait, then the same bank must reactivate
        send(1'b0, 1'b0, 2'd0, 8'd3, 4'd5, 1'b0);
        idle(3);
        do_reset(2);
        idle(1);
        send(1'b0, 1'b0, 2'd0, 8'd3, 4'd5, 1'b0);
        // Randomized traffic with occasional mid-operation resets
        for (int k = 0; k < 80; k++) begin
            int gap;
            gap = $urandom_range(0, 3);
            send(1'($urandom), 1'($urandom), 2'($urandom), 8'($urandom_range(0, 3)),
                 4'($urandom), gap == 0);
            if ($urandom_range(0, 11) == 0) begin
                idle($urandom_range(0, 14));
                do_reset($urandom_range(1, 2));
            end
            if (gap != 0) idle(gap);
        end
        req_valid_in = 1'b0;
        done = 0;
        for (int n = 0; n < 300 && !done; n++) begin
            @(posedge clk_in);
            if (q.size() == 0 && !inflight) done = 1;
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout got %0d pending exp 0", q.size());
        end
        idle(4);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
